// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: forwarding selects, load-use stall, branch flush,
// and multi-cycle memory / mul-div stall sequencing through a small FSM.
// Forwarding and stall/flush outputs are combinational; stall FSM state advances one step per clk.
module pipeline_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MEM_WAIT = 2,
  parameter int MD_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] Rd_E,
  input  logic [REG_AW-1:0] Rd_M,
  input  logic [REG_AW-1:0] Rd_W,
  input  logic              RegWrite_M,
  input  logic              RegWrite_W,
  input  logic              ResultSrc_E_0,
  input  logic              MemAccess_M,
  input  logic              MulDiv_E,
  input  logic [1:0]        PC_Src_E,
  output logic              Stall_F,
  output logic              Stall_D,
  output logic              Stall_E,
  output logic              Stall_M,
  output logic              Flush_D,
  output logic              Flush_E,
  output logic              Flush_M,
  output logic              Flush_W,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic              Busy
);

  typedef enum logic [1:0] {IDLE, MWAIT, MDBUSY} state_t;

  // The trigger cycle already counts as one stall cycle, so the wait state is loaded with N-2.
  localparam logic [4:0] MEM_INIT = (MEM_WAIT >= 2) ? 5'(MEM_WAIT - 2) : 5'd0;
  localparam logic [4:0] MD_INIT  = (MD_LAT   >= 2) ? 5'(MD_LAT   - 2) : 5'd0;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        mem_ack_q, mem_ack_d;
  logic        md_ack_q, md_ack_d;

  logic        is_idle;
  logic        mem_trig;
  logic        md_trig;
  logic        lw_stall;
  logic        redirect;
  logic        mem_stall;
  logic        md_stall;

  assign is_idle  = (state_q == IDLE);
  assign mem_trig = is_idle && MemAccess_M && !mem_ack_q && (MEM_WAIT > 0);
  // The instruction in M is older than the one in E, so a memory access wins a same-cycle tie.
  assign md_trig  = is_idle && MulDiv_E && !md_ack_q && !mem_trig;
  assign lw_stall = ResultSrc_E_0 && (Rd_E != '0) && ((Rs1_D == Rd_E) || (Rs2_D == Rd_E));
  assign redirect = |PC_Src_E;
  assign mem_stall = mem_trig || (state_q == MWAIT);
  assign md_stall  = md_trig  || (state_q == MDBUSY);
  assign Busy      = !is_idle;

  // Forwarding: M has priority over W as it holds the newer value; x0 is never forwarded.
  always_comb begin
    ForwardA_E = 2'b00;
    ForwardB_E = 2'b00;
    if (RegWrite_M && (Rs1_E == Rd_M) && (Rs1_E != '0))      ForwardA_E = 2'b10;
    else if (RegWrite_W && (Rs1_E == Rd_W) && (Rs1_E != '0)) ForwardA_E = 2'b01;
    if (RegWrite_M && (Rs2_E == Rd_M) && (Rs2_E != '0))      ForwardB_E = 2'b10;
    else if (RegWrite_W && (Rs2_E == Rd_W) && (Rs2_E != '0)) ForwardB_E = 2'b01;
  end

  // Next-state: acks live for one cycle only so the released instruction moves exactly once.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_ack_d = 1'b0;
    md_ack_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_trig) begin
          if (MEM_WAIT == 1) begin
            mem_ack_d = 1'b1;
          end else begin
            state_d = MWAIT;
            cnt_d   = MEM_INIT;
          end
        end else if (md_trig) begin
          if (MD_LAT == 1) begin
            md_ack_d = 1'b1;
          end else begin
            state_d = MDBUSY;
            cnt_d   = MD_INIT;
          end
        end
      end
      MWAIT: begin
        if (cnt_q == 5'd0) begin
          state_d   = IDLE;
          mem_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      MDBUSY: begin
        if (cnt_q == 5'd0) begin
          state_d  = IDLE;
          md_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall/flush outputs: long stalls mask load-use and branch flushes, so a held branch
  // only flushes once the stall releases.
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    Flush_M = 1'b0;
    Flush_W = 1'b0;
    if (mem_stall) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
      Flush_W = 1'b1;
    end else if (md_stall) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Flush_M = 1'b1;
    end else begin
      Stall_F = lw_stall;
      Stall_D = lw_stall;
      Flush_D = redirect;
      Flush_E = lw_stall || redirect;
    end
  end

  // State register with asynchronous clear so a reset aborts any stall in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      mem_ack_q <= 1'b0;
      md_ack_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_ack_q <= mem_ack_d;
      md_ack_q  <= md_ack_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with default parameters (REG_AW=5, MEM_WAIT=2, MD_LAT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
// Output vector order: {Stall_F,Stall_D,Stall_E,Stall_M,Flush_D,Flush_E,Flush_M,Flush_W,Busy}.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
  logic       RegWrite_M, RegWrite_W, ResultSrc_E_0, MemAccess_M, MulDiv_E;
  logic [1:0] PC_Src_E;
  logic       Stall_F, Stall_D, Stall_E, Stall_M;
  logic       Flush_D, Flush_E, Flush_M, Flush_W;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       Busy;
  logic [8:0] outs;

  int n_cmp  = 0;
  int n_fail = 0;
  int stall_cycles;

  always #5 clk = ~clk;

  assign outs = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_M, Flush_W, Busy};

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
    .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .ResultSrc_E_0(ResultSrc_E_0), .MemAccess_M(MemAccess_M), .MulDiv_E(MulDiv_E),
    .PC_Src_E(PC_Src_E),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E), .Stall_M(Stall_M),
    .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_M(Flush_M), .Flush_W(Flush_W),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E), .Busy(Busy)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    Rs1_D = '0; Rs2_D = '0; Rs1_E = '0; Rs2_E = '0; Rd_E = '0; Rd_M = '0; Rd_W = '0;
    RegWrite_M = 1'b0; RegWrite_W = 1'b0; ResultSrc_E_0 = 1'b0;
    MemAccess_M = 1'b0; MulDiv_E = 1'b0; PC_Src_E = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #3;
    chk("reset_outs", 16'(outs), 16'h000);
    chk("reset_fwd", 16'({ForwardA_E, ForwardB_E}), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_outs", 16'(outs), 16'h000);

    // Forwarding priority and x0 exclusion
    Rs1_E = 5'd5; Rd_M = 5'd5; RegWrite_M = 1'b1; Rd_W = 5'd5; RegWrite_W = 1'b1; settle();
    chk("fwdA_from_M", 16'(ForwardA_E), 16'h2);
    Rd_M = 5'd6; settle();
    chk("fwdA_from_W", 16'(ForwardA_E), 16'h1);
    Rs1_E = 5'd0; settle();
    chk("fwdA_x0", 16'(ForwardA_E), 16'h0);
    Rs2_E = 5'd6; settle();
    chk("fwdB_from_M", 16'(ForwardB_E), 16'h2);
    RegWrite_M = 1'b0; Rs2_E = 5'd5; settle();
    chk("fwdB_from_W", 16'(ForwardB_E), 16'h1);
    clear_inputs(); settle();

    // Load-use stall
    ResultSrc_E_0 = 1'b1; Rd_E = 5'd3; Rs2_D = 5'd3; settle();
    chk("lw_stall_rs2", 16'(outs), 16'(9'b1100_0100_0));
    Rd_E = 5'd0; Rs2_D = 5'd0; settle();
    chk("lw_to_x0", 16'(outs), 16'h000);
    Rd_E = 5'd9; Rs1_D = 5'd9; settle();
    chk("lw_stall_rs1", 16'(outs), 16'(9'b1100_0100_0));
    clear_inputs();
    PC_Src_E = 2'b10; settle();
    chk("branch_flush", 16'(outs), 16'(9'b0000_1100_0));
    clear_inputs(); settle();

    // Memory access held four cycles: stall, stall, release, re-trigger
    MemAccess_M = 1'b1; settle();
    chk("mem_c1", 16'(outs), 16'(9'b1111_0001_0));
    step();
    chk("mem_c2", 16'(outs), 16'(9'b1111_0001_1));
    step();
    chk("mem_c3_release", 16'(outs), 16'h000);
    step();
    chk("mem_c4_retrig", 16'(outs), 16'(9'b1111_0001_0));
    step();
    MemAccess_M = 1'b0; settle();
    chk("mem_c5_wait", 16'(outs), 16'(9'b1111_0001_1));
    step();
    step();
    chk("mem_done", 16'(outs), 16'h000);

    // Simultaneous mem and mul/div: memory first, then mul/div; held branch waits
    MemAccess_M = 1'b1; MulDiv_E = 1'b1; settle();
    chk("both_mem_first", 16'(outs), 16'(9'b1111_0001_0));
    step();
    MemAccess_M = 1'b0; settle();
    chk("both_mwait", 16'(outs), 16'(9'b1111_0001_1));
    step();
    chk("md_trig", 16'(outs), 16'(9'b1110_0010_0));
    step();
    MulDiv_E = 1'b0; PC_Src_E = 2'b01; settle();
    chk("md_busy_branch_held", 16'(outs), 16'(9'b1110_0010_1));
    Rs1_E = 5'd7; Rd_W = 5'd7; RegWrite_W = 1'b1; settle();
    chk("fwd_in_mdbusy", 16'(ForwardA_E), 16'h1);
    step();
    chk("md_busy2", 16'(outs), 16'(9'b1110_0010_1));
    step();
    chk("md_busy3", 16'(outs), 16'(9'b1110_0010_1));
    step();
    chk("md_release_branch", 16'(outs), 16'(9'b0000_1100_0));
    clear_inputs();
    step();

    // Reset in the middle of a mul/div stall, then a full re-trigger
    MulDiv_E = 1'b1; settle();
    chk("md2_trig", 16'(outs), 16'(9'b1110_0010_0));
    step();
    MulDiv_E = 1'b0; settle();
    chk("md2_busy", 16'(outs), 16'(9'b1110_0010_1));
    rst_n = 1'b0; settle();
    chk("async_reset", 16'(outs), 16'h000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_reset_idle", 16'(outs), 16'h000);
    MulDiv_E = 1'b1; settle();
    stall_cycles = 0;
    for (int i = 0; i < 20 && Stall_E; i++) begin
      stall_cycles++;
      step();
      MulDiv_E = 1'b0; settle();
    end
    chk("md_full_latency", 16'(stall_cycles), 16'd4);
    chk("md_final_idle", 16'(outs), 16'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
